calc_seq_ctrl: RTL and testbench
================================

Name: calc_seq_ctrl

Overview:
Sequencing FSM for the calculator datapath. Takes tokenised key events (digit/operand value, operator, equals, clear) and drives load strobes for the operand-A, operand-B and opcode registers. Starts a multi-cycle ALU through a start/done handshake and flags result-valid or error. Supports chaining: an operator entered after a result reuses that result as operand A.

Parameters:
WIDTH, 8, operand/result data width
OP_W, 2, opcode width
TIMEOUT, 64, max cycles allowed between alu_start_o and alu_done_i (>=2)

Ports:
clock_i  in  1  clock, rising edge
resetb_i  in  1  reset, asynchronous, active-low
key_valid_i  in  1  key event strobe, one cycle per event
key_type_i  in  2  00 operand, 01 operator, 10 equals, 11 clear
key_data_i  in  WIDTH  operand value (type 00) or opcode in [OP_W-1:0] (type 01)
key_ready_o  out  1  controller accepts non-clear keys this cycle
operand_o  out  WIDTH  data bus to operand registers (registered copy of key_data_i)
opcode_o  out  OP_W  data to opcode register
a_sel_o  out  1  operand-A mux select: 0 = operand_o, 1 = ALU result (chaining)
ld_a_o  out  1  load pulse, operand-A register
ld_b_o  out  1  load pulse, operand-B register
ld_op_o  out  1  load pulse, opcode register
alu_start_o  out  1  one-cycle ALU start pulse
alu_done_i  in  1  ALU done pulse
alu_err_i  in  1  ALU error (e.g. divide by zero), sampled with alu_done_i
result_valid_o  out  1  result register holds a valid result
error_o  out  1  sticky error flag
state_o  out  3  current state encoding, for debug/display

Behaviour:
- Reset (async, resetb_i low): state IDLE; all pulses, a_sel_o, result_valid_o, error_o = 0; operand_o, opcode_o = 0; timeout counter = 0. key_ready_o = 1 from the first clock after reset release.
- States and encodings: IDLE=0, GOT_A=1, GOT_OP=2, GOT_B=3, EXEC=4, SHOW=5, ERR=6.
- Key acceptance: an event is accepted when key_valid_i=1 and (key_ready_o=1 or type=clear). Non-clear events with key_ready_o=0 are dropped silently.
- key_ready_o = 1 in all states except EXEC and ERR.
- Output timing: all outputs are registered. Strobes and operand_o/opcode_o/a_sel_o assert in the cycle after acceptance, for exactly one cycle. operand_o/opcode_o hold their value until the next load.
- IDLE: operand -> ld_a_o, a_sel_o=0, go GOT_A. Operator or equals -> ignored, stay.
- GOT_A: operand -> ld_a_o (overwrite A), stay. Operator -> ld_op_o, go GOT_OP. Equals -> ignored.
- GOT_OP: operand -> ld_b_o, go GOT_B. Operator -> ld_op_o (replace opcode), stay. Equals -> ignored.
- GOT_B: operand -> ld_b_o (overwrite B), stay. Operator -> ignored. Equals -> alu_start_o, go EXEC, timeout counter cleared.
- EXEC:
  - Counter increments each cycle.
  - alu_done_i=1 with alu_err_i=0 -> SHOW, result_valid_o=1.
  - alu_done_i=1 with alu_err_i=1 -> ERR, error_o=1.
  - Counter reaches TIMEOUT-1 without done -> ERR, error_o=1.
  - alu_done_i is ignored in all other states.
- SHOW:
  - Operand -> ld_a_o with a_sel_o=0, result_valid_o cleared, go GOT_A.
  - Operator -> ld_a_o with a_sel_o=1 and ld_op_o in the same cycle, result_valid_o cleared, go GOT_OP.
  - Equals -> re-execute with same A/B/op: alu_start_o, go EXEC.
- ERR: only clear leaves. error_o stays 1 until clear.
- Clear, any state including mid-EXEC: next cycle state IDLE, result_valid_o=0, error_o=0, counter=0, no strobes. An alu_done_i arriving after the clear is ignored.
- Simultaneous events:
  - Clear accepted in the same cycle alu_done_i arrives: clear wins.
  - Timeout and done in the same cycle: done wins.
- Reset mid-EXEC: immediate return to IDLE, outputs at reset values, no alu_start_o after release.

Test Plan:
- Basic op: reset; operand 0x12, operator 01, operand 0x05, equals; assert alu_done_i 3 cycles after start -> ld_a_o, ld_op_o, ld_b_o each pulse once with operand_o=0x12/opcode_o=01/operand_o=0x05; alu_start_o one pulse; result_valid_o=1; state_o=5.
- Chaining: from SHOW, operator 10 -> same-cycle ld_a_o=1, a_sel_o=1, ld_op_o=1, opcode_o=10; state_o=2; result_valid_o=0.
- Error/timeout: equals with alu_done_i+alu_err_i -> error_o=1, state_o=6; operand/operator keys ignored; clear -> state_o=0, error_o=0. With TIMEOUT=8 and no done -> error_o=1 exactly 8 cycles after alu_start_o.
- Gating: operator in IDLE, equals in GOT_A, and operand during EXEC -> no strobes, state unchanged; key_ready_o=0 throughout EXEC.
- Clear vs done: clear in the same cycle as alu_done_i -> state_o=0, result_valid_o=0; a later stray alu_done_i has no effect.
- Async reset: drop resetb_i mid-EXEC off-edge -> outputs go to 0 immediately; after release state_o=0 and no alu_start_o.

Source files
------------

// File: rtl/calc_seq_ctrl.sv
// Calculator key sequencer: turns key events into operand/opcode load strobes
// and runs the ALU start/done handshake with timeout, chaining and error handling.
//
// state  | meaning
// IDLE   | nothing entered, waiting for first operand
// GOT_A  | operand A loaded
// GOT_OP | opcode loaded, waiting for operand B
// GOT_B  | operand B loaded, equals starts the ALU
// EXEC   | ALU running, keys other than clear dropped
// SHOW   | result valid; operand restarts, operator chains, equals repeats
// ERR    | ALU error or timeout, only clear leaves
module calc_seq_ctrl #(
  parameter int WIDTH   = 8,
  parameter int OP_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic             key_valid_i,
  input  logic [1:0]       key_type_i,
  input  logic [WIDTH-1:0] key_data_i,
  output logic             key_ready_o,
  output logic [WIDTH-1:0] operand_o,
  output logic [OP_W-1:0]  opcode_o,
  output logic             a_sel_o,
  output logic             ld_a_o,
  output logic             ld_b_o,
  output logic             ld_op_o,
  output logic             alu_start_o,
  input  logic             alu_done_i,
  input  logic             alu_err_i,
  output logic             result_valid_o,
  output logic             error_o,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GOT_A  = 3'd1,
    GOT_OP = 3'd2,
    GOT_B  = 3'd3,
    EXEC   = 3'd4,
    SHOW   = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic accepted;
  logic k_operand;
  logic k_operator;
  logic k_equals;
  logic k_clear;

  // Clear bypasses key_ready_o so it can abort EXEC and leave ERR.
  assign accepted   = key_valid_i && key_ready_o;
  assign k_operand  = accepted && (key_type_i == 2'b00);
  assign k_operator = accepted && (key_type_i == 2'b01);
  assign k_equals   = accepted && (key_type_i == 2'b10);
  assign k_clear    = key_valid_i && (key_type_i == 2'b11);

  assign state_o = state;

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state          <= IDLE;
      cnt            <= '0;
      key_ready_o    <= 1'b0;
      operand_o      <= '0;
      opcode_o       <= '0;
      a_sel_o        <= 1'b0;
      ld_a_o         <= 1'b0;
      ld_b_o         <= 1'b0;
      ld_op_o        <= 1'b0;
      alu_start_o    <= 1'b0;
      result_valid_o <= 1'b0;
      error_o        <= 1'b0;
    end else begin
      ld_a_o      <= 1'b0;
      ld_b_o      <= 1'b0;
      ld_op_o     <= 1'b0;
      alu_start_o <= 1'b0;
      a_sel_o     <= 1'b0;
      key_ready_o <= (state != EXEC) && (state != ERR);

      if (k_clear) begin
        state          <= IDLE;
        cnt            <= '0;
        result_valid_o <= 1'b0;
        error_o        <= 1'b0;
        key_ready_o    <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (k_operand) begin
              ld_a_o    <= 1'b1;
              operand_o <= key_data_i;
              state     <= GOT_A;
            end
          end
          GOT_A: begin
            if (k_operand) begin
              ld_a_o    <= 1'b1;
              operand_o <= key_data_i;
            end else if (k_operator) begin
              ld_op_o  <= 1'b1;
              opcode_o <= key_data_i[OP_W-1:0];
              state    <= GOT_OP;
            end
          end
          GOT_OP: begin
            if (k_operand) begin
              ld_b_o    <= 1'b1;
              operand_o <= key_data_i;
              state     <= GOT_B;
            end else if (k_operator) begin
              ld_op_o  <= 1'b1;
              opcode_o <= key_data_i[OP_W-1:0];
            end
          end
          GOT_B: begin
            if (k_operand) begin
              ld_b_o    <= 1'b1;
              operand_o <= key_data_i;
            end else if (k_equals) begin
              alu_start_o <= 1'b1;
              cnt         <= '0;
              key_ready_o <= 1'b0;
              state       <= EXEC;
            end
          end
          EXEC: begin
            // A done arriving on the last allowed cycle beats the timeout.
            if (alu_done_i) begin
              if (alu_err_i) begin
                error_o <= 1'b1;
                state   <= ERR;
              end else begin
                result_valid_o <= 1'b1;
                key_ready_o    <= 1'b1;
                state          <= SHOW;
              end
            end else if (cnt == CNT_MAX) begin
              error_o <= 1'b1;
              state   <= ERR;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          SHOW: begin
            if (k_operand) begin
              ld_a_o         <= 1'b1;
              operand_o      <= key_data_i;
              result_valid_o <= 1'b0;
              state          <= GOT_A;
            end else if (k_operator) begin
              // Chaining: the previous result becomes operand A.
              ld_a_o         <= 1'b1;
              a_sel_o        <= 1'b1;
              ld_op_o        <= 1'b1;
              opcode_o       <= key_data_i[OP_W-1:0];
              result_valid_o <= 1'b0;
              state          <= GOT_OP;
            end else if (k_equals) begin
              alu_start_o    <= 1'b1;
              cnt            <= '0;
              result_valid_o <= 1'b0;
              key_ready_o    <= 1'b0;
              state          <= EXEC;
            end
          end
          ERR: begin
            state <= ERR;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Scoreboard bench for calc_seq_ctrl: expected strobe bundles are queued as keys
// are driven and compared whenever the controller emits a strobe.
module tb_calc_seq_ctrl;

  logic       clock_i = 1'b0;
  logic       resetb_i = 1'b0;
  logic       key_valid_i = 1'b0;
  logic [1:0] key_type_i = 2'b00;
  logic [7:0] key_data_i = 8'h00;
  logic       alu_done_i = 1'b0;
  logic       alu_err_i = 1'b0;
  logic       key_ready_o;
  logic [7:0] operand_o;
  logic [1:0] opcode_o;
  logic       a_sel_o, ld_a_o, ld_b_o, ld_op_o, alu_start_o;
  logic       result_valid_o, error_o;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [14:0] exp_q[$];
  logic [7:0]  m_operand = 8'h00;
  logic [1:0]  m_opcode = 2'b00;

  calc_seq_ctrl #(.WIDTH(8), .OP_W(2), .TIMEOUT(8)) dut (
    .clock_i(clock_i), .resetb_i(resetb_i),
    .key_valid_i(key_valid_i), .key_type_i(key_type_i), .key_data_i(key_data_i),
    .key_ready_o(key_ready_o), .operand_o(operand_o), .opcode_o(opcode_o),
    .a_sel_o(a_sel_o), .ld_a_o(ld_a_o), .ld_b_o(ld_b_o), .ld_op_o(ld_op_o),
    .alu_start_o(alu_start_o), .alu_done_i(alu_done_i), .alu_err_i(alu_err_i),
    .result_valid_o(result_valid_o), .error_o(error_o), .state_o(state_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bundle layout: {ld_a, ld_b, ld_op, a_sel, start, opcode, operand}
  task automatic expect_strobe(input logic a, input logic b, input logic op,
                               input logic as, input logic st);
    exp_q.push_back({a, b, op, as, st, m_opcode, m_operand});
  endtask

  always @(negedge clock_i) begin
    if (ld_a_o || ld_b_o || ld_op_o || alu_start_o) begin
      if (exp_q.size() == 0)
        check_val("unexpected_strobe",
                  {17'd0, ld_a_o, ld_b_o, ld_op_o, a_sel_o, alu_start_o, opcode_o, operand_o}, 32'd0);
      else
        check_val("strobe_bundle",
                  {17'd0, ld_a_o, ld_b_o, ld_op_o, a_sel_o, alu_start_o, opcode_o, operand_o},
                  {17'd0, exp_q.pop_front()});
    end
  end

  task automatic send(input logic [1:0] t, input logic [7:0] d);
    @(negedge clock_i);
    key_valid_i = 1'b1;
    key_type_i  = t;
    key_data_i  = d;
    @(negedge clock_i);
    key_valid_i = 1'b0;
  endtask

  task automatic pulse_done(input logic e);
    @(negedge clock_i);
    alu_done_i = 1'b1;
    alu_err_i  = e;
    @(negedge clock_i);
    alu_done_i = 1'b0;
    alu_err_i  = 1'b0;
  endtask

  // Loads A, op, B and presses equals, leaving the controller in EXEC.
  task automatic run_to_exec(input logic [7:0] a, input logic [1:0] op, input logic [7:0] b);
    m_operand = a;          expect_strobe(1, 0, 0, 0, 0); send(2'b00, a);
    m_opcode  = op;         expect_strobe(0, 0, 1, 0, 0); send(2'b01, {6'd0, op});
    m_operand = b;          expect_strobe(0, 1, 0, 0, 0); send(2'b00, b);
    expect_strobe(0, 0, 0, 0, 1); send(2'b10, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    logic early;
    logic started;

    repeat (2) @(negedge clock_i);
    check_val("rst_state", state_o, 0);
    check_val("rst_flags", {result_valid_o, error_o, key_ready_o}, 0);
    check_val("rst_data", {operand_o, opcode_o}, 0);
    resetb_i = 1'b1;
    #1 check_val("ready_before_edge", key_ready_o, 0);
    @(negedge clock_i);
    check_val("ready_after_edge", key_ready_o, 1);

    // Gating and the basic operation
    send(2'b01, 8'h02);
    check_val("idle_operator_ignored", state_o, 0);
    m_operand = 8'h12; expect_strobe(1, 0, 0, 0, 0); send(2'b00, 8'h12);
    check_val("got_a", state_o, 1);
    send(2'b10, 8'h00);
    check_val("gota_equals_ignored", state_o, 1);
    m_opcode = 2'b01; expect_strobe(0, 0, 1, 0, 0); send(2'b01, 8'h01);
    check_val("got_op", state_o, 2);
    m_operand = 8'h05; expect_strobe(0, 1, 0, 0, 0); send(2'b00, 8'h05);
    check_val("got_b", state_o, 3);
    expect_strobe(0, 0, 0, 0, 1); send(2'b10, 8'h00);
    check_val("exec", {state_o, key_ready_o}, {3'd4, 1'b0});
    send(2'b00, 8'h33);
    check_val("exec_operand_dropped", {state_o, key_ready_o, operand_o}, {3'd4, 1'b0, 8'h05});
    pulse_done(1'b0);
    check_val("show", {state_o, result_valid_o, error_o, key_ready_o}, {3'd5, 3'b101});

    // Chaining from SHOW
    m_opcode = 2'b10; expect_strobe(1, 0, 1, 1, 0); send(2'b01, 8'h02);
    check_val("chain", {state_o, result_valid_o, opcode_o}, {3'd2, 1'b0, 2'b10});

    // ALU error
    m_operand = 8'h07; expect_strobe(0, 1, 0, 0, 0); send(2'b00, 8'h07);
    expect_strobe(0, 0, 0, 0, 1); send(2'b10, 8'h00);
    pulse_done(1'b1);
    check_val("alu_err", {state_o, error_o, result_valid_o, key_ready_o}, {3'd6, 3'b100});
    send(2'b00, 8'h44);
    send(2'b01, 8'h03);
    check_val("err_keys_dropped", {state_o, error_o}, {3'd6, 1'b1});
    send(2'b11, 8'h00);
    check_val("err_clear", {state_o, error_o, key_ready_o}, {3'd0, 1'b0, 1'b1});

    // Timeout: error exactly 8 cycles after the start pulse
    run_to_exec(8'h01, 2'b11, 8'h02);
    check_val("timeout_start_seen", alu_start_o, 1);
    early = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock_i);
      if (error_o) early = 1'b1;
    end
    check_val("timeout_not_early", early, 0);
    @(negedge clock_i);
    check_val("timeout_err", {state_o, error_o}, {3'd6, 1'b1});
    send(2'b11, 8'h00);
    check_val("timeout_clear", state_o, 0);

    // Clear in the same cycle as done
    run_to_exec(8'h09, 2'b00, 8'h0A);
    @(negedge clock_i);
    key_valid_i = 1'b1; key_type_i = 2'b11; alu_done_i = 1'b1;
    @(negedge clock_i);
    key_valid_i = 1'b0; alu_done_i = 1'b0;
    check_val("clear_wins", {state_o, result_valid_o, error_o}, 0);
    pulse_done(1'b0);
    check_val("stray_done", {state_o, result_valid_o, error_o}, 0);

    // Asynchronous reset mid-EXEC
    run_to_exec(8'h0B, 2'b01, 8'h0C);
    @(negedge clock_i);
    #2 resetb_i = 1'b0;
    #1 check_val("async_rst", {state_o, error_o, key_ready_o, result_valid_o, alu_start_o, operand_o, opcode_o}, 0);
    m_operand = 8'h00; m_opcode = 2'b00;
    @(negedge clock_i);
    resetb_i = 1'b1;
    started = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock_i);
      if (alu_start_o) started = 1'b1;
    end
    check_val("no_start_after_rst", started, 0);
    check_val("rst_release_state", {state_o, key_ready_o}, {3'd0, 1'b1});

    check_val("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
